spdif_stream_ctrl: RTL and testbench

SPDIF_STREAM_CTRL -- requirements
Module: spdif_stream_ctrl

---
 rtl/spdif_stream_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_spdif_stream_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spdif_stream_ctrl.sv
// spdif_stream_ctrl: sample streaming controller between the sample FIFO and
// the S/PDIF frame assembler. It waits for the FIFO to fill, then pops one
// sample for each subframe request and holds it on `sample`. Underruns are
// counted, and a stop request ends streaming at the next subframe boundary.
//
// Optional feature macro: MUTE_ON_UNDERRUN_EN
//   defined   : an underrun outputs a muted (zero) sample and streaming continues
//   undefined : an underrun mutes the output, disables streaming and re-enters
//               prefill (default build)
module spdif_stream_ctrl #(
    parameter int unsigned DATA_W     = 20,
    parameter int unsigned CNT_W      = 10,
    parameter int unsigned FILL_LEVEL = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic [CNT_W-1:0]  fifo_count,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    input  logic              frame_ready,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              stream_en,
    output logic              underrun,
    output logic [7:0]        underrun_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        PREFILL,
        RUN,
        STOP_PEND
    } state_t;

    localparam logic [CNT_W-1:0] FILL_C = CNT_W'(FILL_LEVEL);

    state_t            state_q, state_d;
    logic              fr_q, fr_d;        // registered frame_ready for edge detect
    logic              rd_q, rd_d;        // pop issued this cycle
    logic              cap_q, cap_d;      // FIFO data arrives this cycle
    logic              mute1_q, mute1_d;  // underrun seen one edge ago
`ifdef MUTE_ON_UNDERRUN_EN
    logic              mute2_q, mute2_d;  // muted sample due at this edge
`endif
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              sv_q, sv_d;
    logic              en_q, en_d;
    logic              unr_q, unr_d;
    logic [7:0]        cnt_q, cnt_d;

    logic              req;
    logic              busy;

    assign req = frame_ready & ~fr_q;
`ifdef MUTE_ON_UNDERRUN_EN
    assign busy = rd_q | cap_q | mute1_q | mute2_q;
`else
    assign busy = rd_q | cap_q | mute1_q;
`endif

    // Next-state logic: pop pipeline, underrun handling and state transitions
    always_comb begin
        state_d  = state_q;
        fr_d     = frame_ready;
        rd_d     = 1'b0;
        mute1_d  = 1'b0;
        sample_d = sample_q;
        sv_d     = 1'b0;
        en_d     = en_q;
        unr_d    = 1'b0;
        cnt_d    = cnt_q;
        // A pop suppressed by a late empty flag must not capture stale data.
        cap_d    = rd_q & ~fifo_empty;
`ifdef MUTE_ON_UNDERRUN_EN
        mute2_d  = mute1_q;
`endif

        if (cap_q) begin
            sample_d = fifo_dout;
            sv_d     = 1'b1;
        end
`ifdef MUTE_ON_UNDERRUN_EN
        if (mute2_q) begin
            sample_d = '0;
            sv_d     = 1'b1;
        end
`endif

        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = PREFILL;
                end
            end
            PREFILL: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (fifo_count >= FILL_C) begin
                    state_d = RUN;
                    en_d    = 1'b1;
                end
            end
            RUN: begin
                if (req && !busy) begin
                    if (fifo_empty) begin
                        unr_d   = 1'b1;
                        mute1_d = 1'b1;
                        if (cnt_q != 8'hFF) begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        rd_d = 1'b1;
                    end
                end
                if (stop) begin
                    state_d = STOP_PEND;
                end
            end
            STOP_PEND: begin
                if (req && !busy) begin
                    sample_d = '0;
                    sv_d     = 1'b1;
                    en_d     = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifndef MUTE_ON_UNDERRUN_EN
        // The underrun takes effect one edge after the request; it overrides
        // whatever the state case chose so the block always re-enters prefill.
        if (mute1_q) begin
            sample_d = '0;
            en_d     = 1'b0;
            state_d  = (state_q == STOP_PEND) ? IDLE : PREFILL;
        end
`endif
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            fr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cap_q    <= 1'b0;
            mute1_q  <= 1'b0;
`ifdef MUTE_ON_UNDERRUN_EN
            mute2_q  <= 1'b0;
`endif
            sample_q <= '0;
            sv_q     <= 1'b0;
            en_q     <= 1'b0;
            unr_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            fr_q     <= fr_d;
            rd_q     <= rd_d;
            cap_q    <= cap_d;
            mute1_q  <= mute1_d;
`ifdef MUTE_ON_UNDERRUN_EN
            mute2_q  <= mute2_d;
`endif
            sample_q <= sample_d;
            sv_q     <= sv_d;
            en_q     <= en_d;
            unr_q    <= unr_d;
            cnt_q    <= cnt_d;
        end
    end

    // fifo_rd is masked by the live empty flag so a pop never hits an empty FIFO
    assign fifo_rd      = rd_q & ~fifo_empty;
    assign sample       = sample_q;
    assign sample_valid = sv_q;
    assign stream_en    = en_q;
    assign underrun     = unr_q;
    assign underrun_cnt = cnt_q;

endmodule

// File: tb/tb_spdif_stream_ctrl.sv
// Directed testbench for spdif_stream_ctrl. Works with or without
// MUTE_ON_UNDERRUN_EN; underrun expectations follow the macro.
module tb_spdif_stream_ctrl;

    localparam int DATA_W = 20;
    localparam int CNT_W  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stop;
    logic [DATA_W-1:0] fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_rd;
    logic              frame_ready;
    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic              stream_en;
    logic              underrun;
    logic [7:0]        underrun_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spdif_stream_ctrl #(
        .DATA_W    (DATA_W),
        .CNT_W     (CNT_W),
        .FILL_LEVEL(256)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .fifo_dout   (fifo_dout),
        .fifo_count  (fifo_count),
        .fifo_empty  (fifo_empty),
        .fifo_rd     (fifo_rd),
        .frame_ready (frame_ready),
        .sample      (sample),
        .sample_valid(sample_valid),
        .stream_en   (stream_en),
        .underrun    (underrun),
        .underrun_cnt(underrun_cnt)
    );

    // advance one clock; outputs are observed 1 ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; frame_ready = 1'b0;
        fifo_empty = 1'b1; fifo_count = '0; fifo_dout = '0;
        step(); step();
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_fifo_rd got=%0b exp=0", fifo_rd); end
        checks++; if (sample !== 20'h0) begin errors++; $display("FAIL reset_sample got=%h exp=00000", sample); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", sample_valid); end
        checks++; if (stream_en !== 1'b0) begin errors++; $display("FAIL reset_stream_en got=%0b exp=0", stream_en); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%0b exp=0", underrun); end
        checks++; if (underrun_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", underrun_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_idle_ignore();
        frame_ready = 1'b1; fifo_empty = 1'b1;
        step();
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL idle_underrun got=%0b exp=0", underrun); end
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL idle_fifo_rd got=%0b exp=0", fifo_rd); end
        frame_ready = 1'b0;
        step();
        checks++; if (stream_en !== 1'b0) begin errors++; $display("FAIL idle_stream_en got=%0b exp=0", stream_en); end
    endtask

    task automatic test_prefill();
        start = 1'b1; fifo_count = '0;
        step();
        start = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            fifo_count  = CNT_W'(k * 32);
            fifo_empty  = (k == 0);
            frame_ready = (k % 2 == 1);
            step();
            checks++; if (stream_en !== (k == 8)) begin errors++; $display("FAIL prefill_en count=%0d got=%0b exp=%0b", k * 32, stream_en, (k == 8)); end
            checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL prefill_rd count=%0d got=%0b exp=0", k * 32, fifo_rd); end
        end
    endtask

    task automatic test_pop_timing();
        int pops;
        fifo_empty = 1'b0; fifo_dout = 20'h12345;
        frame_ready = 1'b1;
        step();
        checks++; if (fifo_rd !== 1'b1) begin errors++; $display("FAIL pop_rd_n1 got=%0b exp=1", fifo_rd); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL pop_valid_n1 got=%0b exp=0", sample_valid); end
        step();
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL pop_rd_n2 got=%0b exp=0", fifo_rd); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL pop_valid_n2 got=%0b exp=0", sample_valid); end
        fifo_dout = 20'hABCDE;
        step();
        checks++; if (sample !== 20'hABCDE) begin errors++; $display("FAIL pop_sample got=%h exp=abcde", sample); end
        checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL pop_valid got=%0b exp=1", sample_valid); end
        pops = 0;
        repeat (3) begin
            step();
            if (fifo_rd) pops++;
        end
        checks++; if (pops !== 0) begin errors++; $display("FAIL pop_held_extra got=%0d exp=0", pops); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL pop_valid_after got=%0b exp=0", sample_valid); end
        checks++; if (sample !== 20'hABCDE) begin errors++; $display("FAIL pop_sample_hold got=%h exp=abcde", sample); end
        frame_ready = 1'b0;
        step();
    endtask

    task automatic test_overlap();
        fifo_dout = 20'h5A5A5;
        frame_ready = 1'b1;
        step();
        checks++; if (fifo_rd !== 1'b1) begin errors++; $display("FAIL ovl_rd got=%0b exp=1", fifo_rd); end
        fifo_empty = 1'b1;
        #1;
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL ovl_rd_empty got=%0b exp=0", fifo_rd); end
        fifo_empty = 1'b0;
        #1;
        frame_ready = 1'b0;
        step();
        frame_ready = 1'b1;
        step();
        checks++; if (sample !== 20'h5A5A5) begin errors++; $display("FAIL ovl_sample got=%h exp=5a5a5", sample); end
        checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL ovl_valid got=%0b exp=1", sample_valid); end
        step();
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL ovl_ignored_rd got=%0b exp=0", fifo_rd); end
        step();
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL ovl_ignored_rd2 got=%0b exp=0", fifo_rd); end
        frame_ready = 1'b0;
        step();
    endtask

    task automatic test_underrun();
        fifo_empty = 1'b1; frame_ready = 1'b1;
        step();
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL unr_pulse got=%0b exp=1", underrun); end
        checks++; if (underrun_cnt !== 8'd1) begin errors++; $display("FAIL unr_cnt got=%0d exp=1", underrun_cnt); end
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL unr_rd got=%0b exp=0", fifo_rd); end
        frame_ready = 1'b0; fifo_count = 10'd100;
        step();
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL unr_pulse_end got=%0b exp=0", underrun); end
`ifdef MUTE_ON_UNDERRUN_EN
        checks++; if (stream_en !== 1'b1) begin errors++; $display("FAIL unr_en_n1 got=%0b exp=1", stream_en); end
        step();
        checks++; if (sample !== 20'h0) begin errors++; $display("FAIL unr_sample got=%h exp=00000", sample); end
        checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL unr_valid got=%0b exp=1", sample_valid); end
        checks++; if (stream_en !== 1'b1) begin errors++; $display("FAIL unr_en_n2 got=%0b exp=1", stream_en); end
`else
        checks++; if (stream_en !== 1'b0) begin errors++; $display("FAIL unr_en_n1 got=%0b exp=0", stream_en); end
        checks++; if (sample !== 20'h0) begin errors++; $display("FAIL unr_sample got=%h exp=00000", sample); end
        step();
        checks++; if (stream_en !== 1'b0) begin errors++; $display("FAIL unr_prefill_en got=%0b exp=0", stream_en); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL unr_valid got=%0b exp=0", sample_valid); end
`endif
        fifo_count = 10'd256;
        step();
        checks++; if (stream_en !== 1'b1) begin errors++; $display("FAIL unr_restart_en got=%0b exp=1", stream_en); end
    endtask

    task automatic test_saturation();
        int nunr;
        nunr = 0;
        fifo_empty = 1'b1; fifo_count = 10'd256;
        for (int i = 0; i < 300; i++) begin
            frame_ready = 1'b1;
            step();
            if (underrun) nunr++;
            frame_ready = 1'b0;
            repeat (3) begin
                step();
                if (underrun) nunr++;
            end
            if (i == 99) begin
                checks++; if (underrun_cnt !== 8'd101) begin errors++; $display("FAIL sat_mid_cnt got=%0d exp=101", underrun_cnt); end
            end
        end
        checks++; if (underrun_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt got=%0d exp=255", underrun_cnt); end
        checks++; if (nunr !== 300) begin errors++; $display("FAIL sat_pulses got=%0d exp=300", nunr); end
    endtask

    task automatic test_stop();
        fifo_empty = 1'b0; fifo_dout = 20'h00777;
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        step(); step();
        checks++; if (sample !== 20'h00777) begin errors++; $display("FAIL stop_pre_sample got=%h exp=00777", sample); end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++; if (stream_en !== 1'b1) begin errors++; $display("FAIL stop_pend_en got=%0b exp=1", stream_en); end
        frame_ready = 1'b1;
        step();
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL stop_rd got=%0b exp=0", fifo_rd); end
        checks++; if (sample !== 20'h0) begin errors++; $display("FAIL stop_sample got=%h exp=00000", sample); end
        checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL stop_valid got=%0b exp=1", sample_valid); end
        checks++; if (stream_en !== 1'b0) begin errors++; $display("FAIL stop_en got=%0b exp=0", stream_en); end
        frame_ready = 1'b0;
        step();
        checks++; if (stream_en !== 1'b0) begin errors++; $display("FAIL stop_idle_en got=%0b exp=0", stream_en); end
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        step();
        checks++; if (stream_en !== 1'b0) begin errors++; $display("FAIL startstop_idle_en got=%0b exp=0", stream_en); end
        start = 1'b1; fifo_count = 10'd0;
        step();
        start = 1'b0; stop = 1'b1;
        step();
        stop = 1'b0; fifo_count = 10'd256;
        step();
        step();
        checks++; if (stream_en !== 1'b0) begin errors++; $display("FAIL stop_prefill_en got=%0b exp=0", stream_en); end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++; if (stream_en !== 1'b1) begin errors++; $display("FAIL restart_en got=%0b exp=1", stream_en); end
    endtask

    task automatic test_reset_inflight();
        fifo_dout = 20'hABCDE; frame_ready = 1'b1;
        step();
        checks++; if (fifo_rd !== 1'b1) begin errors++; $display("FAIL rstpop_rd got=%0b exp=1", fifo_rd); end
        rst = 1'b1;
        step();
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL rstpop_rd_clr got=%0b exp=0", fifo_rd); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rstpop_valid got=%0b exp=0", sample_valid); end
        checks++; if (stream_en !== 1'b0) begin errors++; $display("FAIL rstpop_en got=%0b exp=0", stream_en); end
        checks++; if (underrun_cnt !== 8'd0) begin errors++; $display("FAIL rstpop_cnt got=%0d exp=0", underrun_cnt); end
        rst = 1'b0; start = 1'b1; frame_ready = 1'b0;
        step();
        start = 1'b0;
        checks++; if (sample !== 20'h0) begin errors++; $display("FAIL rstpop_sample got=%h exp=00000", sample); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rstpop_nocap got=%0b exp=0", sample_valid); end
        step();
        checks++; if (stream_en !== 1'b1) begin errors++; $display("FAIL rstpop_start got=%0b exp=1", stream_en); end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_prefill();
        test_pop_timing();
        test_overlap();
        test_underrun();
        test_saturation();
        test_stop();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
